// File: rtl/voice_allocator_pkg.sv
// ============================================================================
// voice_allocator_pkg
//   Shared constants, FSM state encoding and apply-action type for the
//   polyphonic voice allocator.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package voice_allocator_pkg;

  localparam int c_NUM_VOICES_DEF = 4;
  localparam int c_KEY_W_DEF      = 7;
  localparam int c_AGE_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_RETRIG  = 2'd1,
    ACT_LOAD    = 2'd2,
    ACT_RELEASE = 2'd3
  } action_t;

endpackage

`default_nettype wire

// File: rtl/voice_allocator_slot.sv
// ============================================================================
// voice_slot
//   Key/gate/age registers for a single oscillator voice.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module voice_slot #(
  parameter int KEY_W = 7,
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             retrig,
  input  logic             rel,
  input  logic             age_inc,
  input  logic [KEY_W-1:0] load_key,
  output logic [KEY_W-1:0] key,
  output logic             gate,
  output logic [AGE_W-1:0] age
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (load) begin
      key  <= load_key;
      gate <= 1'b1;
      age  <= '0;
    end else if (retrig) begin
      age  <= '0;
    end else if (rel) begin
      // key is kept so the oscillator can finish its release tail
      gate <= 1'b0;
    end else if (age_inc && (age != '1)) begin
      age  <= age + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// voice_allocator
//   Maps note-on/note-off key events onto a pool of oscillator voices using a
//   fixed-latency scan (one voice per cycle) followed by a single apply cycle.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = c_NUM_VOICES_DEF,
  parameter int KEY_W      = c_KEY_W_DEF,
  parameter int AGE_W      = c_AGE_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic                              ev_on,
  input  logic [KEY_W-1:0]                  ev_key,
  output logic [NUM_VOICES*KEY_W-1:0]       voice_key,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [$clog2(NUM_VOICES+1)-1:0]   voices_active
);

  localparam int               c_IDX_W    = $clog2(NUM_VOICES);
  localparam int               c_CNT_W    = $clog2(NUM_VOICES+1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_VOICES-1);

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             w_accept;

  logic                             r_on;
  logic [KEY_W-1:0]                 r_key;
  logic [c_IDX_W-1:0]               r_idx;
  logic                             r_match_vld;
  logic [c_IDX_W-1:0]               r_match_idx;
  logic                             r_free_vld;
  logic [c_IDX_W-1:0]               r_free_idx;
  logic                             r_old_vld;
  logic [c_IDX_W-1:0]               r_old_idx;
  logic [AGE_W-1:0]                 r_old_age;

  logic [NUM_VOICES-1:0][KEY_W-1:0] w_slot_key;
  logic [NUM_VOICES-1:0][AGE_W-1:0] w_slot_age;
  logic [KEY_W-1:0]                 w_cur_key;
  logic                             w_cur_gate;
  logic [AGE_W-1:0]                 w_cur_age;

  action_t                          w_action;
  logic [c_IDX_W-1:0]               w_target;
  logic                             w_apply;
  logic [c_CNT_W-1:0]               w_cnt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ev_ready    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_idx == c_LAST_IDX) w_state_nxt = ST_APPLY;
      end
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- scan
  assign w_slot_key = voice_key;
  assign w_cur_key  = w_slot_key[r_idx];
  assign w_cur_gate = voice_gate[r_idx];
  assign w_cur_age  = w_slot_age[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_on        <= 1'b0;
      r_key       <= '0;
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_old_vld   <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
    end else if (w_accept) begin
      r_on        <= ev_on;
      r_key       <= ev_key;
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_free_vld  <= 1'b0;
      r_old_vld   <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      r_idx <= r_idx + 1'b1;
      if (w_cur_gate && (w_cur_key == r_key) && !r_match_vld) begin
        r_match_vld <= 1'b1;
        r_match_idx <= r_idx;
      end
      if (!w_cur_gate && !r_free_vld) begin
        r_free_vld <= 1'b1;
        r_free_idx <= r_idx;
      end
      // strict compare keeps the lowest index on equal ages
      if (w_cur_gate && (!r_old_vld || (w_cur_age > r_old_age))) begin
        r_old_vld <= 1'b1;
        r_old_idx <= r_idx;
        r_old_age <= w_cur_age;
      end
    end
  end

  // ---------------------------------------------------------------- apply
  assign w_apply = (r_state == ST_APPLY);

  always_comb begin
    w_action = ACT_NONE;
    w_target = '0;
    if (r_key != '0) begin
      if (r_on) begin
        if (r_match_vld) begin
          w_action = ACT_RETRIG;
          w_target = r_match_idx;
        end else if (r_free_vld) begin
          w_action = ACT_LOAD;
          w_target = r_free_idx;
        end else begin
          w_action = ACT_LOAD;
          w_target = r_old_idx;
        end
      end else if (r_match_vld) begin
        w_action = ACT_RELEASE;
        w_target = r_match_idx;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      logic w_sel;
      logic w_on_act;

      assign w_sel    = (w_target == c_IDX_W'(g));
      assign w_on_act = (w_action == ACT_LOAD) || (w_action == ACT_RETRIG);

      voice_slot #(
        .KEY_W (KEY_W),
        .AGE_W (AGE_W)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (w_apply && w_sel && (w_action == ACT_LOAD)),
        .retrig   (w_apply && w_sel && (w_action == ACT_RETRIG)),
        .rel      (w_apply && w_sel && (w_action == ACT_RELEASE)),
        .age_inc  (w_apply && w_on_act && !w_sel && voice_gate[g]),
        .load_key (r_key),
        .key      (voice_key[g*KEY_W +: KEY_W]),
        .gate     (voice_gate[g]),
        .age      (w_slot_age[g])
      );
    end
  endgenerate

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_cnt = w_cnt + {{(c_CNT_W-1){1'b0}}, voice_gate[i]};
    end
  end

  assign voices_active = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// tb_voice_allocator
//   Directed-event bench with an expected-state queue checked on each update.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 7;

  logic            clk;
  logic            rst;
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_on;
  logic [KW-1:0]   ev_key;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0]   voice_gate;
  logic [2:0]      voices_active;

  typedef struct packed {
    logic [NV*KW-1:0] keys;
    logic [NV-1:0]    gate;
    logic [2:0]       act;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   vectors    = 0;
  int   miscompares = 0;
  int   lowcnt     = 0;
  int   n_acc      = 0;

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_on         (ev_on),
    .ev_key        (ev_key),
    .voice_key     (voice_key),
    .voice_gate    (voice_gate),
    .voices_active (voices_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic exp_t mk(input int k0, input int k1, input int k2, input int k3,
                              input logic [3:0] g, input int a);
    exp_t e;
    e.keys = {KW'(k3), KW'(k2), KW'(k1), KW'(k0)};
    e.gate = g;
    e.act  = 3'(a);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) n_acc++;
  end

  // Monitor: an update is presented when ev_ready returns high after a busy period
  always @(negedge clk) begin
    if (rst) begin
      lowcnt = 0;
    end else if (!ev_ready) begin
      lowcnt++;
    end else if (lowcnt != 0) begin
      if (q.size() == 0) begin
        check("unexpected_update", 32'(lowcnt), 32'(0));
      end else begin
        me = q.pop_front();
        check("voice_key", 32'(voice_key), 32'(me.keys));
        check("voice_gate", 32'(voice_gate), 32'(me.gate));
        check("voices_active", 32'(voices_active), 32'(me.act));
        check("ready_low_cycles", 32'(lowcnt), 32'(5));
      end
      lowcnt = 0;
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ev_ready && n < 20);
    if (!ev_ready) check(name, 32'(ev_ready), 32'(1));
  endtask

  task automatic send(input logic on, input int key, input exp_t e, input int hold);
    q.push_back(e);
    @(posedge clk); #1;
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = KW'(key);
    wait_ready("accept_timeout");
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1 ev_valid = 1'b0;
    wait_ready("complete_timeout");
  endtask

  initial begin
    int a0;
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 32'(ev_ready), 32'(1));
    check("rst_gate", 32'(voice_gate), 32'(0));
    check("rst_key", 32'(voice_key), 32'(0));
    check("rst_active", 32'(voices_active), 32'(0));

    // single key, retrigger, unmatched off, reserved key 0
    send(1'b1, 60, mk(60, 0, 0, 0, 4'b0001, 1), 0);
    send(1'b1, 60, mk(60, 0, 0, 0, 4'b0001, 1), 0);
    send(1'b0, 99, mk(60, 0, 0, 0, 4'b0001, 1), 0);
    send(1'b1, 0,  mk(60, 0, 0, 0, 4'b0001, 1), 0);

    // reset in the middle of a scan discards the event
    @(posedge clk); #1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = KW'(72);
    @(posedge clk); #1 ev_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("midscan_ready", 32'(ev_ready), 32'(1));
    check("midscan_gate", 32'(voice_gate), 32'(0));
    check("midscan_key", 32'(voice_key), 32'(0));
    check("midscan_active", 32'(voices_active), 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_gate", 32'(voice_gate), 32'(0));
    check("post_rst_key", 32'(voice_key), 32'(0));

    // fill three voices then release them (keys retained)
    send(1'b1, 60, mk(60, 0, 0, 0, 4'b0001, 1), 0);
    send(1'b1, 64, mk(60, 64, 0, 0, 4'b0011, 2), 0);
    send(1'b1, 67, mk(60, 64, 67, 0, 4'b0111, 3), 0);
    send(1'b0, 60, mk(60, 64, 67, 0, 4'b0110, 2), 0);
    send(1'b0, 64, mk(60, 64, 67, 0, 4'b0100, 1), 0);
    send(1'b0, 67, mk(60, 64, 67, 0, 4'b0000, 0), 0);

    // fill all four then steal the oldest twice
    send(1'b1, 25, mk(25, 64, 67, 0, 4'b0001, 1), 0);
    send(1'b1, 30, mk(25, 30, 67, 0, 4'b0011, 2), 0);
    send(1'b1, 35, mk(25, 30, 35, 0, 4'b0111, 3), 0);
    send(1'b1, 40, mk(25, 30, 35, 40, 4'b1111, 4), 0);
    send(1'b1, 45, mk(45, 30, 35, 40, 4'b1111, 4), 0);
    send(1'b1, 50, mk(45, 50, 35, 40, 4'b1111, 4), 0);

    // a released voice is reused before any steal
    send(1'b0, 35, mk(45, 50, 35, 40, 4'b1011, 3), 0);
    send(1'b1, 70, mk(45, 50, 70, 40, 4'b1111, 4), 0);

    // retrigger of voice3 makes it youngest; voice0 then voice1 get stolen
    send(1'b1, 40, mk(45, 50, 70, 40, 4'b1111, 4), 0);
    send(1'b1, 80, mk(80, 50, 70, 40, 4'b1111, 4), 0);
    send(1'b1, 90, mk(80, 90, 70, 40, 4'b1111, 4), 0);

    // ev_valid held through the busy window yields a single accept
    a0 = n_acc;
    send(1'b0, 99, mk(80, 90, 70, 40, 4'b1111, 4), 4);
    check("held_valid_accepts", 32'(n_acc - a0), 32'(1));

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
